score_sequencer: RTL and testbench
==================================

# score_sequencer

Per-note scoring controller for GAME_PLAY. It opens a judgement window on each beat tick and captures rising edges on the two lane buttons. It then judges the capture against the expected note mask, updates combo and multiplier, and applies one saturating score addition per note. It sits between the beat/chart source and the score display, owns score and combo state, and is cleared on song selection.

## Interface
- WINDOW, 8: judgement window length in clk cycles (≥2).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- current_state  in  2  game state: 0 IDLE, 1 SONG_SELECT, 2 GAME_PLAY, 3 GAME_OVER.
- beat_tick  in  1  one-cycle pulse marking the start of a note slot.
- note  in  2  expected lanes for this slot; sampled on the accepted beat_tick.
- btn  in  2  synchronized, debounced lane buttons (level).
- hit_mask  out  2  lanes hit in the last judged note.
- combo  out  8  consecutive fully-hit notes, saturating at 255.
- max_combo  out  8  highest combo since last clear.
- multiplier  out  5  current multiplier, 1..17.
- score  out  16  accumulated score, saturating at 65535.
- score_valid  out  1  one-cycle pulse when score/hit_mask for a note update.
- overrun  out  1  sticky: beat_tick arrived while busy.

## Operation
- Reset: FSM S_IDLE; hit_mask, combo, max_combo, score, score_valid, overrun = 0; multiplier = 1; btn_prev = 0; capture = 0.
- Edge detect: rise = btn & ~btn_prev; btn_prev updates every cycle. A button held across window start is not a press.
- The FSM has four states:
  - S_IDLE: if current_state==2 and beat_tick, latch note and clear capture, then go to S_WINDOW with counter = 0.
  - S_WINDOW: capture |= rise. After WINDOW cycles, go to S_JUDGE.
  - S_JUDGE: hit_mask <= capture & note_l. Presses on lanes outside note_l are ignored.
    - If note_l==capture_masked and note_l≠0, combo increments, saturating at 255.
    - Else if note_l≠0, combo <= 0.
    - If note_l==0, combo is unchanged.
    - max_combo tracks max(max_combo, new combo).
    - multiplier <= f(new combo): 1 if combo==0, else ((combo−1)>>4)+2.
  - S_UPDATE: add = 2 × popcount(hit_mask) × multiplier, max 68. score <= min(score+add, 65535), computed in 17 bits. Assert score_valid next cycle. Return to S_IDLE.
- beat_tick in any state other than S_IDLE sets overrun and is otherwise ignored.
- current_state==1 (SONG_SELECT), every cycle:
  - FSM goes to S_IDLE.
  - score, combo, max_combo, hit_mask, overrun and capture are cleared; multiplier = 1.
  - score_valid = 0.
- current_state==0 or 3: an in-progress window or judgement is aborted with no state update. FSM goes to S_IDLE and all outputs hold.
- If current_state leaves 2 in the same cycle as beat_tick, the tick is ignored.
- A rest note (note_l==0) still runs a window and pulses score_valid with add = 0.

## Timing
- beat_tick accepted at cycle t:
  - Window covers edges in cycles t+1..t+WINDOW.
  - S_JUDGE at t+WINDOW+1.
  - combo, multiplier and max_combo are visible at t+WINDOW+2.
  - score and hit_mask are visible, and score_valid pulses, at t+WINDOW+3.
- The FSM is back in S_IDLE at t+WINDOW+3, and a beat_tick in that cycle is accepted. Minimum beat spacing is WINDOW+3 cycles.
- An edge in cycle t (the beat_tick cycle) is not captured. An edge in cycle t+WINDOW is captured.
- rst mid-operation returns everything to reset values on the next edge, regardless of current_state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Perfect hit: state 2, beat_tick with note=11, btn rises on both lanes at t+3 → at t+10, combo=1 and multiplier=2. At t+11, hit_mask=11, score=8, score_valid=1 for one cycle.
- Partial hit after combo 20 (multiplier 3): note=11, only lane0 pressed → combo=0, multiplier=1, hit_mask=01, score +2. max_combo stays 20.
- Saturation: 255 perfect 11-notes → combo=255, multiplier=17, and each further note adds 68 with combo holding at 255. Continue until score reaches 65535; the next note leaves score=65535.
- Edge rules: btn0 held high from before beat_tick through the window → hit_mask=00 and combo reset. A second beat_tick at t+4 → overrun=1 and no extra judgement.
- Abort/clear: state changes 2→3 at t+5 mid-window → no score_valid and score unchanged. Then state 1 for one cycle → score, combo, max_combo and overrun = 0, multiplier = 1.
- Rest note and reset: note=00 with stray presses → hit_mask=00, combo unchanged, score_valid with add 0. rst asserted during S_WINDOW → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/score_sequencer_if.sv
// Bundle between the beat/chart source and the score display for score_sequencer.
// The master side drives game state, beat ticks, notes and buttons; the slave side returns scoring results.
interface score_sequencer_if;
  logic [1:0]  current_state;
  logic        beat_tick;
  logic [1:0]  note;
  logic [1:0]  btn;
  logic [1:0]  hit_mask;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [4:0]  multiplier;
  logic [15:0] score;
  logic        score_valid;
  logic        overrun;

  modport master (
    output current_state, beat_tick, note, btn,
    input  hit_mask, combo, max_combo, multiplier, score, score_valid, overrun
  );

  modport slave (
    input  current_state, beat_tick, note, btn,
    output hit_mask, combo, max_combo, multiplier, score, score_valid, overrun
  );
endinterface

// File: rtl/score_sequencer.sv
// Per-note scoring controller: opens a judgement window per beat, captures button rises,
// then updates combo/multiplier and applies one saturating score addition per note.
module score_sequencer #(
  parameter int WINDOW = 8
) (
  input logic clk,
  input logic rst,
  score_sequencer_if.slave bus
);

  localparam int CW = $clog2(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WINDOW,
    S_JUDGE,
    S_UPDATE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [1:0]    btn_prev;
  logic [1:0]    capture;
  logic [1:0]    note_l;
  logic [1:0]    judged;
  logic [1:0]    hit_mask_q;
  logic [7:0]    combo_q;
  logic [7:0]    max_combo_q;
  logic [4:0]    multiplier_q;
  logic [15:0]   score_q;
  logic          score_valid_q;
  logic          overrun_q;

  logic [1:0]    rise;
  logic [1:0]    masked;
  logic [7:0]    combo_new;
  logic [7:0]    combo_dec;
  logic [4:0]    mult_new;
  logic [1:0]    pop;
  logic [6:0]    add;
  logic [16:0]   sum;
  logic [15:0]   score_new;

  assign rise = bus.btn & ~btn_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Song select and the non-play states both force the FSM home; only play advances it.
  always_comb begin
    state_next = state;
    case (bus.current_state)
      2'd2: begin
        case (state)
          S_IDLE:   if (bus.beat_tick) state_next = S_WINDOW;
          S_WINDOW: if (cnt == CW'(WINDOW - 1)) state_next = S_JUDGE;
          S_JUDGE:  state_next = S_UPDATE;
          S_UPDATE: state_next = S_IDLE;
          default:  state_next = S_IDLE;
        endcase
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    masked    = capture & note_l;
    combo_new = combo_q;
    if (note_l != 2'b00) begin
      if (masked == note_l) combo_new = (combo_q == 8'd255) ? 8'd255 : combo_q + 8'd1;
      else                  combo_new = 8'd0;
    end
    combo_dec = combo_new - 8'd1;
    mult_new  = (combo_new == 8'd0) ? 5'd1 : {1'b0, combo_dec[7:4]} + 5'd2;
    pop       = {1'b0, judged[0]} + {1'b0, judged[1]};
    add       = 7'({pop, 1'b0}) * 7'(multiplier_q);
    sum       = {1'b0, score_q} + {10'd0, add};
    score_new = sum[16] ? 16'hFFFF : sum[15:0];
  end

  // Datapath: outputs only change in play (judge/update) or are cleared on song select;
  // idle/game-over states abort any in-flight note without touching results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      btn_prev      <= 2'b00;
      capture       <= 2'b00;
      note_l        <= 2'b00;
      judged        <= 2'b00;
      hit_mask_q    <= 2'b00;
      combo_q       <= 8'd0;
      max_combo_q   <= 8'd0;
      multiplier_q  <= 5'd1;
      score_q       <= 16'd0;
      score_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      btn_prev      <= bus.btn;
      score_valid_q <= 1'b0;
      if (bus.current_state == 2'd1) begin
        capture      <= 2'b00;
        hit_mask_q   <= 2'b00;
        combo_q      <= 8'd0;
        max_combo_q  <= 8'd0;
        multiplier_q <= 5'd1;
        score_q      <= 16'd0;
        overrun_q    <= 1'b0;
      end else if (bus.current_state == 2'd2) begin
        if (bus.beat_tick && state != S_IDLE) overrun_q <= 1'b1;
        case (state)
          S_IDLE: begin
            if (bus.beat_tick) begin
              note_l  <= bus.note;
              capture <= 2'b00;
              cnt     <= '0;
            end
          end
          S_WINDOW: begin
            capture <= capture | rise;
            cnt     <= cnt + CW'(1);
          end
          S_JUDGE: begin
            judged       <= masked;
            combo_q      <= combo_new;
            multiplier_q <= mult_new;
            if (combo_new > max_combo_q) max_combo_q <= combo_new;
          end
          S_UPDATE: begin
            hit_mask_q    <= judged;
            score_q       <= score_new;
            score_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.hit_mask    = hit_mask_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.multiplier  = multiplier_q;
  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Scoreboard bench for score_sequencer: a note-level reference model queues expected results,
// and a negedge monitor pops and compares them whenever score_valid pulses.
module tb_score_sequencer;

  localparam int W = 8;

  typedef struct {
    int hit;
    int score;
    int combo;
    int maxc;
    int mult;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  score_sequencer_if bus();

  score_sequencer #(.WINDOW(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic [1:0] lv [0:W+2];

  int m_hit, m_score, m_combo, m_max, m_mult, m_overrun;

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hit = 0; m_score = 0; m_combo = 0; m_max = 0; m_mult = 1; m_overrun = 0;
  endtask

  // Note-level reference: which lanes were pressed (rose) inside the window, then scoring rules.
  task automatic model_note(input int n, output exp_t e);
    int risen, hit, pc;
    risen = 0;
    for (int k = 1; k <= W; k++)
      for (int l = 0; l < 2; l++)
        if (lv[k][l] && !lv[k-1][l]) risen |= (1 << l);
    hit = risen & n;
    if (n != 0) m_combo = (hit == n) ? ((m_combo < 255) ? m_combo + 1 : 255) : 0;
    if (m_combo > m_max) m_max = m_combo;
    m_mult = (m_combo == 0) ? 1 : (m_combo + 15) / 16 + 1;
    pc = (hit & 1) + ((hit >> 1) & 1);
    m_score = m_score + 2 * pc * m_mult;
    if (m_score > 65535) m_score = 65535;
    m_hit = hit;
    e.hit = m_hit; e.score = m_score; e.combo = m_combo; e.maxc = m_max; e.mult = m_mult;
  endtask

  task automatic cyc(input logic [1:0] cs, input logic tick, input logic [1:0] n, input logic [1:0] b);
    bus.current_state = cs;
    bus.beat_tick     = tick;
    bus.note          = n;
    bus.btn           = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic [1:0] cs);
    for (int i = 0; i < cycles; i++) cyc(cs, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".hit_mask"},    int'(bus.hit_mask), 0);
    chk({tag, ".combo"},       int'(bus.combo), 0);
    chk({tag, ".max_combo"},   int'(bus.max_combo), 0);
    chk({tag, ".multiplier"},  int'(bus.multiplier), 1);
    chk({tag, ".score"},       int'(bus.score), 0);
    chk({tag, ".score_valid"}, int'(bus.score_valid), 0);
    chk({tag, ".overrun"},     int'(bus.overrun), 0);
  endtask

  task automatic set_perfect();
    for (int k = 0; k <= W + 2; k++) lv[k] = (k >= 3) ? 2'b11 : 2'b00;
  endtask

  task automatic set_random();
    lv[0] = 2'($urandom_range(0, 3));
    for (int k = 1; k <= W + 2; k++) begin
      lv[k] = lv[k-1];
      for (int l = 0; l < 2; l++)
        if ($urandom_range(0, 3) == 0) lv[k][l] = ~lv[k-1][l];
    end
  endtask

  // tick_at/abort_at/rst_at: cycle offset after the accepted beat (negative = unused).
  task automatic play_note(input logic [1:0] n, input int tick_at, input int abort_at, input int rst_at);
    exp_t e;
    logic [1:0] cs;
    bit live;
    live = (abort_at < 0) && (rst_at < 0);
    if (live) begin
      model_note(int'(n), e);
      q.push_back(e);
    end
    cyc(2'd2, 1'b1, n, lv[0]);
    for (int k = 1; k <= W + 2; k++) begin
      cs = (abort_at >= 0 && k >= abort_at) ? 2'd3 : 2'd2;
      if (k == rst_at) rst = 1'b1;
      cyc(cs, 1'(k == tick_at), n, lv[k]);
      if (k == rst_at) begin
        rst = 1'b0;
        check_cleared("rst_mid_window");
        model_reset();
      end
      if (live && k == W + 1) begin
        chk("early.combo",      int'(bus.combo), m_combo);
        chk("early.multiplier", int'(bus.multiplier), m_mult);
        chk("early.max_combo",  int'(bus.max_combo), m_max);
      end
    end
    if (tick_at >= 1) m_overrun = 1;
  endtask

  task automatic song_select();
    cyc(2'd1, 1'b0, 2'b00, 2'b00);
    model_reset();
    check_cleared("song_select");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.score_valid === 1'b1) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_score_valid: got 1, expected 0");
        end else begin
          e = q.pop_front();
          chk("sv.hit_mask",   int'(bus.hit_mask), e.hit);
          chk("sv.score",      int'(bus.score), e.score);
          chk("sv.combo",      int'(bus.combo), e.combo);
          chk("sv.max_combo",  int'(bus.max_combo), e.maxc);
          chk("sv.multiplier", int'(bus.multiplier), e.mult);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    int iters;
    model_reset();
    rst = 1'b1;
    idle(3, 2'd0);
    rst = 1'b0;
    check_cleared("reset");

    set_perfect();
    play_note(2'b11, -1, -1, -1);
    idle(2, 2'd2);
    chk("perfect.score", int'(bus.score), 8);

    for (int i = 0; i < 60; i++) begin
      set_random();
      play_note(2'($urandom_range(0, 3)), -1, -1, -1);
      idle($urandom_range(0, 3), 2'd2);
    end

    song_select();
    for (int i = 0; i < 20; i++) begin
      set_perfect();
      play_note(2'b11, -1, -1, -1);
    end
    for (int k = 0; k <= W + 2; k++) lv[k] = (k >= 2) ? 2'b01 : 2'b00;
    play_note(2'b11, -1, -1, -1);
    idle(2, 2'd2);
    chk("partial.max_combo", int'(bus.max_combo), 20);
    chk("partial.score", int'(bus.score), m_score);

    set_perfect();
    play_note(2'b11, -1, -1, -1);
    for (int k = 0; k <= W + 2; k++) lv[k] = 2'b01;
    play_note(2'b11, -1, -1, -1);
    idle(2, 2'd2);
    chk("held.combo", int'(bus.combo), 0);
    chk("pre_overrun.overrun", int'(bus.overrun), 0);

    set_perfect();
    play_note(2'b11, 4, -1, -1);
    idle(3, 2'd2);
    chk("overrun.flag", int'(bus.overrun), m_overrun);

    set_perfect();
    play_note(2'b11, -1, 5, -1);
    idle(4, 2'd3);
    chk("abort.score", int'(bus.score), m_score);
    chk("abort.combo", int'(bus.combo), m_combo);
    song_select();

    for (int i = 0; i < 3; i++) begin
      set_perfect();
      play_note(2'b11, -1, -1, -1);
    end
    set_random();
    lv[4] = 2'b00;
    lv[5] = 2'b11;
    play_note(2'b00, -1, -1, -1);
    idle(2, 2'd2);
    chk("rest.combo", int'(bus.combo), 3);

    set_perfect();
    play_note(2'b11, -1, -1, 3);
    idle(2, 2'd2);

    iters = 0;
    while (m_score < 65535 && iters < 2000) begin
      set_perfect();
      play_note(2'b11, -1, -1, -1);
      iters++;
    end
    set_perfect();
    play_note(2'b11, -1, -1, -1);
    idle(3, 2'd2);
    chk("sat.score", int'(bus.score), 65535);
    chk("sat.combo", int'(bus.combo), 255);
    chk("sat.multiplier", int'(bus.multiplier), 17);

    idle(4, 2'd2);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
